// File: rtl/tlul_adapter_dev.sv
// tlul_adapter_dev: TL-UL responder bridging A/D channels to a single-outstanding req/ack register bus.
module tlul_adapter_dev #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int AIW = 8,
  parameter int SZW = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [2:0]        a_opcode_i,
  input  logic [2:0]        a_param_i,
  input  logic [SZW-1:0]    a_size_i,
  input  logic [AIW-1:0]    a_source_i,
  input  logic [AW-1:0]     a_address_i,
  input  logic [DW/8-1:0]   a_mask_i,
  input  logic [DW-1:0]     a_data_i,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [2:0]        d_opcode_o,
  output logic [SZW-1:0]    d_size_o,
  output logic [AIW-1:0]    d_source_o,
  output logic [DW-1:0]     d_data_o,
  output logic              d_error_o,
  output logic              req_o,
  output logic              we_o,
  output logic [AW-1:0]     addr_o,
  output logic [DW-1:0]     wdata_o,
  output logic [DW/8-1:0]   be_o,
  input  logic              ack_i,
  input  logic [DW-1:0]     rdata_i,
  input  logic              err_i
);
  localparam int DBW = DW / 8;
  localparam int OW  = $clog2(DBW);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic is_get, we_q, err_q;
  logic [SZW-1:0] size_q;
  logic [AIW-1:0] source_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [DBW-1:0] be_q, win;
  logic [DBW:0] ones;
  logic [OW-1:0] off_mask;
  logic is_put, legal;
  // Lane window of the addressed 2^size bytes; out-of-range sizes are rejected separately.
  always_comb begin
    ones = ((DBW+1)'(1) << (32'd1 << a_size_i)) - (DBW+1)'(1);
    win = ones[DBW-1:0] << a_address_i[OW-1:0];
    off_mask = OW'((32'd1 << a_size_i) - 32'd1);
    is_put = a_opcode_i == 3'd0 || a_opcode_i == 3'd1;
    legal = (is_put || a_opcode_i == 3'd4) && a_param_i == 3'd0 && 32'(a_size_i) <= OW
         && (a_address_i[OW-1:0] & off_mask) == '0 && (a_mask_i & ~win) == '0
         && !(a_opcode_i == 3'd0 && a_mask_i != win) && !(is_put && a_mask_i == '0);
  end
  always_comb begin
    state_n = (state == IDLE && a_valid_i) ? (legal ? ACCESS : RESP)
            : (state == ACCESS && ack_i) ? RESP
            : (state == RESP && d_ready_i) ? IDLE : state;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      is_get <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= '0;
      source_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q <= '0;
    end else if (state == IDLE && a_valid_i) begin
      is_get <= a_opcode_i == 3'd4;
      we_q <= is_put;
      err_q <= !legal;
      size_q <= a_size_i;
      source_q <= a_source_i;
      addr_q <= {a_address_i[AW-1:OW], {OW{1'b0}}};
      wdata_q <= a_data_i;
      rdata_q <= '0;
      be_q <= (a_opcode_i == 3'd4) ? '1 : a_mask_i;
    end else if (state == ACCESS && ack_i) begin
      rdata_q <= rdata_i;
      err_q <= err_i;
    end
  end
  assign a_ready_o = rst_ni && state == IDLE;
  assign req_o = state == ACCESS;
  assign we_o = req_o && we_q;
  assign addr_o = req_o ? addr_q : '0;
  assign wdata_o = req_o ? wdata_q : '0;
  assign be_o = req_o ? be_q : '0;
  assign d_valid_o = state == RESP;
  assign d_opcode_o = {2'b00, d_valid_o && is_get};
  assign d_size_o = d_valid_o ? size_q : '0;
  assign d_source_o = d_valid_o ? source_q : '0;
  assign d_error_o = d_valid_o && err_q;
  assign d_data_o = (d_valid_o && is_get) ? (err_q ? '1 : rdata_q) : '0;
endmodule

// File: tb/tb_tlul_adapter_dev.sv
// tb_tlul_adapter_dev: directed checks of the TL-UL responder adapter.
module tb_tlul_adapter_dev;
  logic clk_i = 0, rst_ni = 0;
  logic a_valid_i = 0, a_ready_o;
  logic [2:0] a_opcode_i = 0, a_param_i = 0;
  logic [1:0] a_size_i = 0;
  logic [7:0] a_source_i = 0;
  logic [31:0] a_address_i = 0;
  logic [3:0] a_mask_i = 0;
  logic [31:0] a_data_i = 0;
  logic d_valid_o, d_ready_i = 0;
  logic [2:0] d_opcode_o;
  logic [1:0] d_size_o;
  logic [7:0] d_source_o;
  logic [31:0] d_data_o;
  logic d_error_o;
  logic req_o, we_o;
  logic [31:0] addr_o, wdata_o;
  logic [3:0] be_o;
  logic ack_i = 0, err_i = 0;
  logic [31:0] rdata_i = 0;
  int n_cmp = 0, n_err = 0;

  tlul_adapter_dev dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i), .a_param_i(a_param_i),
    .a_size_i(a_size_i), .a_source_i(a_source_i), .a_address_i(a_address_i), .a_mask_i(a_mask_i),
    .a_data_i(a_data_i), .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_opcode_o(d_opcode_o),
    .d_size_o(d_size_o), .d_source_o(d_source_o), .d_data_o(d_data_o), .d_error_o(d_error_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .ack_i(ack_i), .rdata_i(rdata_i), .err_i(err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] prm, input logic [1:0] sz,
                      input logic [7:0] src, input logic [31:0] adr, input logic [3:0] msk,
                      input logic [31:0] dat);
    @(negedge clk_i);
    chk("a_ready_idle", a_ready_o, 1);
    a_valid_i = 1; a_opcode_i = op; a_param_i = prm; a_size_i = sz;
    a_source_i = src; a_address_i = adr; a_mask_i = msk; a_data_i = dat;
    @(negedge clk_i);
    a_valid_i = 0;
  endtask

  task automatic access(input logic ewe, input logic [31:0] eaddr, input logic [31:0] ewdata,
                        input logic [3:0] ebe, input int delay, input logic [31:0] rd, input logic er);
    chk("req", req_o, 1);
    chk("a_ready_access", a_ready_o, 0);
    chk("we", we_o, ewe);
    chk("addr", addr_o, eaddr);
    chk("wdata", wdata_o, ewdata);
    chk("be", be_o, ebe);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      chk("req_hold", req_o, 1);
      chk("addr_hold", addr_o, eaddr);
      chk("be_hold", be_o, ebe);
    end
    ack_i = 1; rdata_i = rd; err_i = er;
    @(negedge clk_i);
    ack_i = 0; rdata_i = 32'h0BAD_0BAD; err_i = 0;
  endtask

  task automatic resp(input logic [2:0] eop, input logic eerr, input logic [31:0] edata,
                      input logic [7:0] esrc, input logic [1:0] esz, input int stall);
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk_i);
      chk("d_valid", d_valid_o, 1);
      chk("d_opcode", d_opcode_o, eop);
      chk("d_error", d_error_o, eerr);
      chk("d_data", d_data_o, edata);
      chk("d_source", d_source_o, esrc);
      chk("d_size", d_size_o, esz);
      chk("req_in_resp", req_o, 0);
      chk("a_ready_resp", a_ready_o, 0);
    end
    d_ready_i = 1;
    @(negedge clk_i);
    d_ready_i = 0;
    chk("d_valid_done", d_valid_o, 0);
    chk("a_ready_back", a_ready_o, 1);
  endtask

  logic [2:0]  il_op  [7] = '{3'd4, 3'd2, 3'd0, 3'd4, 3'd4, 3'd1, 3'd1};
  logic [2:0]  il_prm [7] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
  logic [1:0]  il_sz  [7] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd0};
  logic [31:0] il_adr [7] = '{32'h3001, 32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h3001};
  logic [3:0]  il_msk [7] = '{4'hF, 4'hF, 4'h7, 4'hF, 4'hF, 4'h0, 4'h4};
  logic [2:0]  il_eop [7] = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
  logic [31:0] il_edt [7] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_a_ready", a_ready_o, 0);
    chk("rst_d_valid", d_valid_o, 0);
    chk("rst_req", req_o, 0);
    chk("rst_d_data", d_data_o, 0);
    @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
    chk("post_rst_a_ready", a_ready_o, 1);
    ack_i = 1;
    @(negedge clk_i);
    ack_i = 0;
    chk("stray_ack_ignored", d_valid_o, 0);

    send(3'd4, 0, 2, 8'h5A, 32'h1004, 4'hF, 32'h0);
    access(0, 32'h1004, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 0);
    resp(3'd1, 0, 32'hDEAD_BEEF, 8'h5A, 2, 0);

    send(3'd1, 0, 1, 8'h21, 32'h2002, 4'hC, 32'h1234_0000);
    access(1, 32'h2000, 32'h1234_0000, 4'hC, 0, 32'h0, 0);
    resp(3'd0, 0, 32'h0, 8'h21, 1, 0);

    for (int i = 0; i < 7; i++) begin
      send(il_op[i], il_prm[i], il_sz[i], 8'(8'h30 + i), il_adr[i], il_msk[i], 32'h5555_5555);
      chk("illegal_no_req", req_o, 0);
      resp(il_eop[i], 1, il_edt[i], 8'(8'h30 + i), il_sz[i], 0);
    end

    send(3'd4, 0, 0, 8'h07, 32'h0103, 4'h8, 32'h0);
    access(0, 32'h0100, 32'h0, 4'hF, 0, 32'h1122_3344, 0);
    resp(3'd1, 0, 32'h1122_3344, 8'h07, 0, 0);

    send(3'd4, 0, 2, 8'h11, 32'h0040, 4'hF, 32'h0);
    access(0, 32'h0040, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 0);
    resp(3'd1, 0, 32'hCAFE_F00D, 8'h11, 2, 5);

    send(3'd0, 0, 2, 8'h66, 32'h0080, 4'hF, 32'hA5A5_0101);
    access(1, 32'h0080, 32'hA5A5_0101, 4'hF, 0, 32'h0, 1);
    resp(3'd0, 1, 32'h0, 8'h66, 2, 0);

    send(3'd4, 0, 2, 8'h77, 32'h0200, 4'hF, 32'h0);
    chk("pre_rst_req", req_o, 1);
    rst_ni = 0;
    #1;
    chk("midrst_req", req_o, 0);
    chk("midrst_d_valid", d_valid_o, 0);
    chk("midrst_a_ready", a_ready_o, 0);
    @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
    chk("after_rst_a_ready", a_ready_o, 1);
    chk("after_rst_d_valid", d_valid_o, 0);
    send(3'd4, 0, 2, 8'h78, 32'h0204, 4'hF, 32'h0);
    access(0, 32'h0204, 32'h0, 4'hF, 0, 32'h0123_4567, 0);
    resp(3'd1, 0, 32'h0123_4567, 8'h78, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
